ex_wb_stage: RTL and testbench
==============================

Name: ex_wb_stage

Overview:
- Pipeline stage between EX and the register-file write port of the 4-stage processor.
- Latches the EX result, destination register and write-enable.
- Holds loads until memory data returns, back-pressuring EX meanwhile.
- Drives Writereg/Regwrite/Osrc to the forwarding unit and a one-cycle write strobe to the register file.

Parameters:
- DW, 8, datapath width of ALU result, memory read data and wb_data.
- RW, 3, register address width (Rd/Writereg).

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX presents an instruction this cycle.
- ex_rd  in  RW  destination register of the EX instruction.
- ex_regwrite  in  1  EX instruction writes the register file.
- ex_osrc  in  1  result source: 0 = ALU, 1 = memory load.
- ex_alu_result  in  DW  ALU result.
- flush  in  1  discard the EX instruction offered this cycle.
- mem_rdata  in  DW  load data from data memory.
- mem_ready  in  1  mem_rdata valid this cycle.
- Writereg  out  RW  destination register of the instruction in WB.
- Regwrite  out  1  instruction in WB will write (to forwarding unit).
- Osrc  out  1  source type of the instruction in WB (1 = data not yet forwardable).
- wb_data  out  DW  write-back data.
- rf_we  out  1  register-file write strobe, one cycle per retiring writer.
- stall  out  1  EX must hold its instruction.
- retire_count  out  16  retired-instruction counter (see Optional Feature).

Behaviour:
- States:
  - EMPTY: no instruction in WB.
  - WRITE: final data held; retires this cycle.
  - WAIT_MEM: load awaiting mem_ready.
- State, Writereg, Osrc, wb_data and the latched regwrite are registers. Regwrite, rf_we and stall decode combinationally from state plus those registers.
- Reset, any state, any cycle, including mid-WAIT_MEM:
  - state=EMPTY; Writereg=0, Osrc=0, wb_data=0, latched regwrite=0.
  - Regwrite=0, rf_we=0, stall=0, retire_count=0.
  - The pending load is abandoned; a later mem_ready is ignored.
- EMPTY or WRITE, on edge:
  - If ex_valid & ~flush: latch ex_rd→Writereg, ex_regwrite, ex_osrc→Osrc.
    - ex_osrc=0: wb_data<=ex_alu_result; next=WRITE.
    - ex_osrc=1: wb_data unchanged; next=WAIT_MEM. Loads always spend ≥1 cycle in WAIT_MEM; mem_ready in the capture cycle is ignored.
  - Else: next=EMPTY; Writereg/Osrc/wb_data hold their values.
- WAIT_MEM, on edge:
  - mem_ready=1: wb_data<=mem_rdata; Osrc<=0; next=WRITE.
  - Otherwise stay. EX inputs are ignored; flush has no effect on the resident load.
- Outputs:
  - stall = (state==WAIT_MEM).
  - Regwrite = latched regwrite & (state==WRITE or WAIT_MEM).
  - rf_we = latched regwrite & (state==WRITE).
  - Forwarding therefore sees Osrc=1 with Regwrite=1 during WAIT_MEM (no forward), and Osrc=0 in WRITE (forward wb_data).
- Latency: ALU instruction is accepted on edge N and rf_we is high during cycle N+1. Load: rf_we is high in the cycle after the mem_ready edge.
- Back-to-back ALU instructions: WRITE→WRITE every cycle, no bubble.
- Regwrite=0 instruction: passes through WRITE with rf_we=0 and still counts as retired.
- flush together with ex_valid: the instruction is dropped; the stage goes EMPTY unless in WAIT_MEM.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined: retire_count increments by 1 on every edge where state==WRITE. It is 16-bit, wraps 0xFFFF→0x0000, and is cleared by Reset.
- Undefined: no counter logic; retire_count tied to 0.

Test Plan:
- Reset, then ex_valid=1, ex_rd=3, ex_regwrite=1, ex_osrc=0, ex_alu_result=0x5A -> next cycle Writereg=3, Regwrite=1, Osrc=0, rf_we=1, wb_data=0x5A; following cycle rf_we=0.
- Load ex_rd=5, ex_osrc=1; mem_ready low 3 cycles, then mem_rdata=0xC3 -> stall=1, Regwrite=1, Osrc=1, rf_we=0 for 3 cycles; then wb_data=0xC3, Osrc=0, rf_we=1, stall=0.
- ALU instructions to regs 1, 2, 4 on consecutive cycles -> rf_we high 3 consecutive cycles with Writereg 1, 2, 4; stall never asserted.
- ex_valid=1 with flush=1 while EMPTY -> no state change, rf_we=0; flush=1 during WAIT_MEM -> load still completes on mem_ready.
- Reset pulse while in WAIT_MEM, then mem_ready=1 -> all outputs 0, state EMPTY, no rf_we.
- With WB_RETIRE_CNT_EN: 5 ALU plus 1 load retirements -> retire_count=6; without the macro it stays 0.

Source files
------------

// File: rtl/ex_wb_stage_if.sv
// ----------------------------------------------------------------------------
// ex_wb_stage_if
//
// Purpose:
//   Bundles the signals of the EX -> WB pipeline stage into one interface:
//     - the instruction offer from EX,
//     - the load-data return from data memory,
//     - the write-back / forwarding outputs of the stage.
//
// Modports:
//   master : the EX stage, data memory and forwarding side.
//            Drives the EX offer and the memory return; observes WB outputs.
//   slave  : the ex_wb_stage itself.
//
// Signals:
//   ex_valid      EX presents an instruction this cycle
//   ex_rd         destination register of the EX instruction
//   ex_regwrite   EX instruction writes the register file
//   ex_osrc       result source: 0 = ALU, 1 = memory load
//   ex_alu_result ALU result
//   flush         discard the EX instruction offered this cycle
//   mem_rdata     load data from data memory
//   mem_ready     mem_rdata valid this cycle
//   Writereg      destination register of the instruction in WB
//   Regwrite      instruction in WB will write (to forwarding unit)
//   Osrc          source type in WB (1 = data not yet forwardable)
//   wb_data       write-back data
//   rf_we         register-file write strobe, one cycle per retiring writer
//   stall         EX must hold its instruction
//
// Handshake:
//   EX -> WB uses valid/ready semantics with ready = ~stall. An instruction
//   transfers on a rising edge where ex_valid=1, stall=0 and flush=0. While
//   stall=1, EX must keep its offer stable; the stage ignores it. mem_ready
//   is a one-way valid qualifying mem_rdata and has no back-pressure.
// ----------------------------------------------------------------------------
interface ex_wb_stage_if #(
    parameter int DW = 8,
    parameter int RW = 3
);
    logic          ex_valid;
    logic [RW-1:0] ex_rd;
    logic          ex_regwrite;
    logic          ex_osrc;
    logic [DW-1:0] ex_alu_result;
    logic          flush;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    logic [RW-1:0] Writereg;
    logic          Regwrite;
    logic          Osrc;
    logic [DW-1:0] wb_data;
    logic          rf_we;
    logic          stall;

    modport master (
        output ex_valid, ex_rd, ex_regwrite, ex_osrc, ex_alu_result, flush,
        output mem_rdata, mem_ready,
        input  Writereg, Regwrite, Osrc, wb_data, rf_we, stall
    );

    modport slave (
        input  ex_valid, ex_rd, ex_regwrite, ex_osrc, ex_alu_result, flush,
        input  mem_rdata, mem_ready,
        output Writereg, Regwrite, Osrc, wb_data, rf_we, stall
    );
endinterface

// File: rtl/ex_wb_stage.sv
// ----------------------------------------------------------------------------
// ex_wb_stage
//
// Purpose:
//   Pipeline stage between EX and the register-file write port. Latches the
//   EX result, destination register and write-enable; holds loads until
//   memory data returns (stalling EX meanwhile); drives Writereg/Regwrite/
//   Osrc to the forwarding unit and a one-cycle write strobe to the RF.
//
// Ports:
//   Clk          clock, all state updates on the rising edge
//   Reset        synchronous, active-high reset
//   bus          ex_wb_stage_if.slave (EX offer, memory return, WB outputs)
//   retire_count 16-bit retired-instruction counter
//   state_dbg    current FSM state (0 = EMPTY, 1 = WRITE, 2 = WAIT_MEM)
//
// Configuration:
//   WB_RETIRE_CNT_EN  when defined, retire_count counts every edge spent in
//                     WRITE (16-bit, wrapping, cleared by Reset). When not
//                     defined, retire_count is tied to zero.
// ----------------------------------------------------------------------------
module ex_wb_stage #(
    parameter int DW = 8,
    parameter int RW = 3
) (
    input  logic                Clk,
    input  logic                Reset,
    ex_wb_stage_if.slave        bus,
    output logic [15:0]         retire_count,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        WRITE    = 2'd1,
        WAIT_MEM = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] writereg_q, writereg_nxt;
    logic          osrc_q, osrc_nxt;
    logic [DW-1:0] wb_data_q, wb_data_nxt;
    logic          regwrite_q, regwrite_nxt;
    logic          accept;

    // An offer is taken only from EMPTY/WRITE; in WAIT_MEM the stall makes
    // EX hold, so its inputs (including flush) are not looked at.
    assign accept = bus.ex_valid & ~bus.flush;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= EMPTY;
            writereg_q <= '0;
            osrc_q     <= 1'b0;
            wb_data_q  <= '0;
            regwrite_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            writereg_q <= writereg_nxt;
            osrc_q     <= osrc_nxt;
            wb_data_q  <= wb_data_nxt;
            regwrite_q <= regwrite_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        writereg_nxt = writereg_q;
        osrc_nxt     = osrc_q;
        wb_data_nxt  = wb_data_q;
        regwrite_nxt = regwrite_q;
        case (state)
            EMPTY, WRITE: begin
                if (accept) begin
                    writereg_nxt = bus.ex_rd;
                    regwrite_nxt = bus.ex_regwrite;
                    osrc_nxt     = bus.ex_osrc;
                    if (bus.ex_osrc) begin
                        // Load: data is never taken in the capture cycle,
                        // even if mem_ready happens to be high.
                        state_nxt = WAIT_MEM;
                    end else begin
                        wb_data_nxt = bus.ex_alu_result;
                        state_nxt   = WRITE;
                    end
                end else begin
                    state_nxt = EMPTY;
                end
            end
            WAIT_MEM: begin
                if (bus.mem_ready) begin
                    wb_data_nxt = bus.mem_rdata;
                    // Data is now final, so forwarding may use it.
                    osrc_nxt    = 1'b0;
                    state_nxt   = WRITE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    assign bus.Writereg = writereg_q;
    assign bus.Osrc     = osrc_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.stall    = (state == WAIT_MEM);
    // Regwrite stays visible during WAIT_MEM so forwarding sees a pending
    // writer with Osrc=1 and refuses to forward from it.
    assign bus.Regwrite = regwrite_q & ((state == WRITE) | (state == WAIT_MEM));
    assign bus.rf_we    = regwrite_q & (state == WRITE);
    assign state_dbg    = state;

`ifdef WB_RETIRE_CNT_EN
    logic [15:0] retire_cnt_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            retire_cnt_q <= 16'd0;
        end else if (state == WRITE) begin
            retire_cnt_q <= retire_cnt_q + 16'd1;
        end
    end

    assign retire_count = retire_cnt_q;
`else
    assign retire_count = 16'd0;
`endif

endmodule

// File: tb/tb_ex_wb_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_wb_stage
//
// Directed-vector bench for ex_wb_stage. Inputs are driven 1 time unit after
// each rising edge; outputs are observed at the same point, i.e. they show
// the state produced by the edge just taken.
// ----------------------------------------------------------------------------
module tb_ex_wb_stage;

    localparam int DW = 8;
    localparam int RW = 3;

`ifdef WB_RETIRE_CNT_EN
    localparam int RETIRED_EXP = 7;
`else
    localparam int RETIRED_EXP = 0;
`endif

    // ---------------- clock / reset ----------------
    logic        Clk;
    logic        Reset;
    logic [15:0] retire_count;
    logic [1:0]  state_dbg;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    ex_wb_stage_if #(.DW(DW), .RW(RW)) bus ();

    ex_wb_stage #(.DW(DW), .RW(RW)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .bus          (bus.slave),
        .retire_count (retire_count),
        .state_dbg    (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Checks every WB-side output in one go.
    task automatic expect_out(input string t, input int st, input int wreg,
                              input int rw, input int os, input int wb,
                              input int we, input int stl);
        check({t, ".state"},    32'(state_dbg),    st);
        check({t, ".Writereg"}, 32'(bus.Writereg), wreg);
        check({t, ".Regwrite"}, 32'(bus.Regwrite), rw);
        check({t, ".Osrc"},     32'(bus.Osrc),     os);
        check({t, ".wb_data"},  32'(bus.wb_data),  wb);
        check({t, ".rf_we"},    32'(bus.rf_we),    we);
        check({t, ".stall"},    32'(bus.stall),    stl);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ex_valid      = 1'b0;
        bus.ex_rd         = '0;
        bus.ex_regwrite   = 1'b0;
        bus.ex_osrc       = 1'b0;
        bus.ex_alu_result = '0;
        bus.flush         = 1'b0;
        bus.mem_rdata     = '0;
        bus.mem_ready     = 1'b0;
    endtask

    task automatic offer(input logic [RW-1:0] rd, input logic rw,
                         input logic os, input logic [DW-1:0] alu);
        bus.ex_valid      = 1'b1;
        bus.ex_rd         = rd;
        bus.ex_regwrite   = rw;
        bus.ex_osrc       = os;
        bus.ex_alu_result = alu;
    endtask

    localparam int S_EMPTY = 0;
    localparam int S_WRITE = 1;
    localparam int S_WAIT  = 2;

    // Expected write-back stream for the back-to-back test.
    logic [RW-1:0] exp_q[$];

    initial begin
        idle_inputs();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;

        // Reset state
        expect_out("reset", S_EMPTY, 0, 0, 0, 0, 0, 0);
        check("reset.retire", 32'(retire_count), 0);

        // Single ALU instruction, one-cycle latency
        offer(3'd3, 1'b1, 1'b0, 8'h5A);
        step();
        idle_inputs();
        expect_out("alu1", S_WRITE, 3, 1, 0, 'h5A, 1, 0);
        step();
        expect_out("alu1_done", S_EMPTY, 3, 0, 0, 'h5A, 0, 0);

        // Load with 3 waiting cycles; mem_ready in capture cycle is ignored
        offer(3'd5, 1'b1, 1'b1, 8'h00);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 8'h11;
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            expect_out($sformatf("ld_wait%0d", i), S_WAIT, 5, 1, 1, 'h5A, 0, 1);
            if (i < 2) step();
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 8'hC3;
        step();
        idle_inputs();
        expect_out("ld_done", S_WRITE, 5, 1, 0, 'hC3, 1, 0);
        step();
        expect_out("ld_after", S_EMPTY, 5, 0, 0, 'hC3, 0, 0);

        // Back-to-back ALU writes to 1, 2, 4: no bubble, no stall
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd4);
        for (int i = 0; i < 3; i++) begin
            logic [RW-1:0] rd;
            rd = exp_q[i];
            offer(rd, 1'b1, 1'b0, 8'(8'h11 * (i + 1)));
            step();
            expect_out($sformatf("b2b%0d", i), S_WRITE, int'(exp_q[i]), 1, 0,
                       (i + 1) * 'h11, 1, 0);
        end
        idle_inputs();
        step();
        check("b2b_end.rf_we", 32'(bus.rf_we), 0);
        check("b2b_end.state", 32'(state_dbg), S_EMPTY);

        // Flushed offer while EMPTY: dropped, registers hold
        offer(3'd6, 1'b1, 1'b0, 8'hEE);
        bus.flush = 1'b1;
        step();
        idle_inputs();
        expect_out("flush_empty", S_EMPTY, 4, 0, 0, 'h33, 0, 0);

        // Flush during WAIT_MEM does not disturb the resident load
        offer(3'd7, 1'b1, 1'b1, 8'h00);
        step();
        offer(3'd2, 1'b1, 1'b0, 8'h55);
        bus.flush = 1'b1;
        step();
        expect_out("flush_wait", S_WAIT, 7, 1, 1, 'h33, 0, 1);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 8'h9E;
        step();
        idle_inputs();
        expect_out("flush_wait_done", S_WRITE, 7, 1, 0, 'h9E, 1, 0);
        step();

        // Non-writing instruction passes through WRITE without a strobe
        offer(3'd6, 1'b0, 1'b0, 8'h77);
        step();
        idle_inputs();
        expect_out("nowrite", S_WRITE, 6, 0, 0, 'h77, 0, 0);
        step();
        check("nowrite_after.state", 32'(state_dbg), S_EMPTY);

        // 5 ALU + 2 load retirements so far
        check("retire_count", 32'(retire_count), RETIRED_EXP);

        // Reset in WAIT_MEM abandons the load; later mem_ready is ignored
        offer(3'd3, 1'b1, 1'b1, 8'h00);
        step();
        idle_inputs();
        check("rst_mid.stall", 32'(bus.stall), 1);
        Reset = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 8'hAA;
        step();
        Reset = 1'b0;
        expect_out("rst_mid", S_EMPTY, 0, 0, 0, 0, 0, 0);
        step();
        expect_out("rst_after_ready", S_EMPTY, 0, 0, 0, 0, 0, 0);
        check("rst_after_ready.retire", 32'(retire_count), 0);
        idle_inputs();

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
